// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// A chain of DEPTH pipeline registers carrying a generic payload (DATA_W) and
// control word (CTRL_W) with a valid bit per stage. Each stage can be stalled
// or flushed. When a held stage has a moving stage directly downstream, the
// moving stage is filled with a bubble. A bubble is all-zero, so ctrl == 0
// always means "no side effects".
//
// Optional build macro: PIPE_STAGE_CHAIN_PERF_EN
//   When it is defined, two saturating counters are built:
//     stall_cnt counts cycles with in_ready low.
//     kill_cnt  counts valid entries destroyed by flush.
//   When it is not defined, both counters read 0 and perf_clr is ignored.
//   Stage behaviour is the same in both builds.

module pipe_stage_chain #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 16,
   parameter int DEPTH  = 1,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DEPTH-1:0]  stall,
   input  logic [DEPTH-1:0]  flush,
   input  logic              perf_clr,
   output logic              in_ready,
   output logic [DEPTH-1:0]  stage_valid,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  kill_cnt
);

   // hold[i] is set when stage i or any stage downstream of it is stalled.
   logic [DEPTH-1:0]             hold;

   // Flattened view of every stage register, indexed by stage number.
   logic [DEPTH-1:0]             vld_w;
   logic [DEPTH-1:0][DATA_W-1:0] data_w;
   logic [DEPTH-1:0][CTRL_W-1:0] ctrl_w;

   // Hold vector: OR-reduce the stalls from the tail of the chain towards the head.
   always_comb begin
      logic acc;
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      // NOTE: blocking '=' is used here because acc must ripple through the loop within one evaluation.
      acc  = 1'b0;
      hold = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         acc     = acc | stall[i];
         hold[i] = acc;
      end
   end

   assign in_ready = ~hold[0];

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic              up_valid;
      logic [DATA_W-1:0] up_data;
      logic [CTRL_W-1:0] up_ctrl;
      logic              up_hold;

      logic              valid_q;
      logic [DATA_W-1:0] data_q;
      logic [CTRL_W-1:0] ctrl_q;

      if (i == 0) begin : g_head
         // An idle input cycle is loaded as a clean bubble. This keeps junk
         // ctrl bits on the bus from entering the pipe.
         assign up_valid = in_valid;
         assign up_data  = in_valid ? in_data : '0;
         assign up_ctrl  = in_valid ? in_ctrl : '0;
         assign up_hold  = 1'b0;
      end else begin : g_body
         assign up_valid = vld_w[i-1];
         assign up_data  = data_w[i-1];
         assign up_ctrl  = ctrl_w[i-1];
         assign up_hold  = hold[i-1];
      end

      // Stage register priority: flush, then hold, then bubble behind a held upstream stage, then advance.
      always_ff @(posedge CLK or negedge reset) begin
         if (!reset) begin
            // NOTE: the payload is reset along with valid because a bubble is defined as all-zero and out_data must read 0 in reset.
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
         end else if (flush[i]) begin
            // NOTE: non-blocking '<=' so every stage samples its neighbour's pre-edge value.
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
         end else if (hold[i]) begin
            // Contents held. A flushed bubble stays a bubble here.
            valid_q <= valid_q;
            data_q  <= data_q;
            ctrl_q  <= ctrl_q;
         end else if (up_hold) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
         end else begin
            valid_q <= up_valid;
            data_q  <= up_data;
            ctrl_q  <= up_ctrl;
         end
      end

      assign vld_w[i]  = valid_q;
      assign data_w[i] = data_q;
      assign ctrl_w[i] = ctrl_q;
   end

   assign stage_valid = vld_w;
   assign out_valid   = vld_w[DEPTH-1];
   assign out_data    = data_w[DEPTH-1];
   assign out_ctrl    = ctrl_w[DEPTH-1];

`ifdef PIPE_STAGE_CHAIN_PERF_EN
   logic [2:0]       kill_inc;
   logic [CNT_W+2:0] kill_sum;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] kill_q;

   // Number of valid entries destroyed this cycle, and the unsaturated new kill total.
   always_comb begin
      kill_inc = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill_inc = kill_inc + {2'b00, flush[i] & vld_w[i]};
      end
      kill_sum = {3'b000, kill_q} + {{CNT_W{1'b0}}, kill_inc};
   end

   // Saturating statistics counters. A clear takes priority over an increment.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         kill_q  <= '0;
      end else if (perf_clr) begin
         stall_q <= '0;
         kill_q  <= '0;
      end else begin
         if (!in_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (kill_sum > {3'b000, {CNT_W{1'b1}}}) begin
            kill_q <= '1;
         end else begin
            kill_q <= kill_sum[CNT_W-1:0];
         end
      end
   end

   assign stall_cnt = stall_q;
   assign kill_cnt  = kill_q;
`else
   // Counters are not built in this configuration.
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;
   assign stall_cnt       = '0;
   assign kill_cnt        = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain
// Directed bench for pipe_stage_chain. It instantiates three chains:
//   DEPTH=3: streaming, bubble insertion, reset mid-stall.
//   DEPTH=2: flush over stall.
//   DEPTH=4, CNT_W=4: multi-kill and counter saturation.
// Counter expectations follow PIPE_STAGE_CHAIN_PERF_EN.

module tb_pipe_stage_chain;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   logic CLK = 1'b0;
   logic reset;

   always #5 CLK = ~CLK;

   // DEPTH=3 chain
   logic       a_valid;
   logic [7:0] a_data;
   logic [3:0] a_ctrl;
   logic [2:0] a_stall;
   logic [2:0] a_flush;
   logic       a_ready;
   logic [2:0] a_sv;
   logic       a_ov;
   logic [7:0] a_od;
   logic [3:0] a_oc;
   logic [7:0] a_sc;
   logic [7:0] a_kc;

   // DEPTH=2 chain
   logic       b_valid;
   logic [7:0] b_data;
   logic [3:0] b_ctrl;
   logic [1:0] b_stall;
   logic [1:0] b_flush;
   logic       b_ready;
   logic [1:0] b_sv;
   logic       b_ov;
   logic [7:0] b_od;
   logic [3:0] b_oc;
   logic [7:0] b_sc;
   logic [7:0] b_kc;

   // DEPTH=4 chain with 4-bit counters
   logic       c_valid;
   logic [7:0] c_data;
   logic [3:0] c_ctrl;
   logic [3:0] c_stall;
   logic [3:0] c_flush;
   logic       c_clr;
   logic       c_ready;
   logic [3:0] c_sv;
   logic       c_ov;
   logic [7:0] c_od;
   logic [3:0] c_oc;
   logic [3:0] c_sc;
   logic [3:0] c_kc;

   pipe_stage_chain #(.DATA_W(8), .CTRL_W(4), .DEPTH(3), .CNT_W(8)) u_d3 (
      .CLK(CLK), .reset(reset), .in_valid(a_valid), .in_data(a_data), .in_ctrl(a_ctrl),
      .stall(a_stall), .flush(a_flush), .perf_clr(1'b0), .in_ready(a_ready),
      .stage_valid(a_sv), .out_valid(a_ov), .out_data(a_od), .out_ctrl(a_oc),
      .stall_cnt(a_sc), .kill_cnt(a_kc)
   );

   pipe_stage_chain #(.DATA_W(8), .CTRL_W(4), .DEPTH(2), .CNT_W(8)) u_d2 (
      .CLK(CLK), .reset(reset), .in_valid(b_valid), .in_data(b_data), .in_ctrl(b_ctrl),
      .stall(b_stall), .flush(b_flush), .perf_clr(1'b0), .in_ready(b_ready),
      .stage_valid(b_sv), .out_valid(b_ov), .out_data(b_od), .out_ctrl(b_oc),
      .stall_cnt(b_sc), .kill_cnt(b_kc)
   );

   pipe_stage_chain #(.DATA_W(8), .CTRL_W(4), .DEPTH(4), .CNT_W(4)) u_d4 (
      .CLK(CLK), .reset(reset), .in_valid(c_valid), .in_data(c_data), .in_ctrl(c_ctrl),
      .stall(c_stall), .flush(c_flush), .perf_clr(c_clr), .in_ready(c_ready),
      .stage_valid(c_sv), .out_valid(c_ov), .out_data(c_od), .out_ctrl(c_oc),
      .stall_cnt(c_sc), .kill_cnt(c_kc)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock and settle 1 ns past the edge before sampling or driving.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [7:0] d, input logic [3:0] c);
      a_valid = v; a_data = d; a_ctrl = c;
   endtask

   initial begin
      reset = 1'b0;
      drive_a(1'b0, 8'h00, 4'h0); a_stall = '0; a_flush = '0;
      b_valid = 1'b0; b_data = '0; b_ctrl = '0; b_stall = '0; b_flush = '0;
      c_valid = 1'b0; c_data = '0; c_ctrl = '0; c_stall = '0; c_flush = '0; c_clr = 1'b0;

      // Reset state
      #3;
      check("rst_sv",    32'(a_sv), 32'h0);
      check("rst_ov",    32'(a_ov), 32'h0);
      check("rst_od",    32'(a_od), 32'h0);
      check("rst_ready", 32'(a_ready), 32'h1);
      #9 reset = 1'b1;
      step();

      // Streaming: three entries out on cycles 3, 4, 5
      drive_a(1'b1, 8'h11, 4'h1); step();
      check("str_lat", 32'(a_ov), 32'h0);
      drive_a(1'b1, 8'h22, 4'h2); step();
      drive_a(1'b1, 8'h33, 4'h3); step();
      check("str_d0", 32'(a_od), 32'h11);
      check("str_v0", 32'(a_ov), 32'h1);
      check("str_c0", 32'(a_oc), 32'h1);
      drive_a(1'b0, 8'h00, 4'h0); step();
      check("str_d1", 32'(a_od), 32'h22);
      step();
      check("str_d2", 32'(a_od), 32'h33);
      check("str_v2", 32'(a_ov), 32'h1);
      step();
      check("str_drain_v", 32'(a_ov), 32'h0);
      check("str_drain_c", 32'(a_oc), 32'h0);

      // Bubble insertion: C in stage 2, B in stage 1, A in stage 0, then stall[1] for 2 cycles
      drive_a(1'b1, 8'hC0, 4'hC); step();
      drive_a(1'b1, 8'hB0, 4'hB); step();
      drive_a(1'b1, 8'hA0, 4'hA); step();
      drive_a(1'b1, 8'hD0, 4'hD);
      a_stall = 3'b010;
      #1;
      check("bub_ready0", 32'(a_ready), 32'h0);
      check("bub_c_out",  32'(a_od), 32'hC0);
      step();
      check("bub1_ov", 32'(a_ov), 32'h0);
      check("bub1_oc", 32'(a_oc), 32'h0);
      check("bub1_sv", 32'(a_sv), 32'h3);
      step();
      check("bub2_ov",    32'(a_ov), 32'h0);
      check("bub2_sv",    32'(a_sv), 32'h3);
      check("bub2_ready", 32'(a_ready), 32'h0);
      a_stall = 3'b000;
      #1;
      check("bub_ready1", 32'(a_ready), 32'h1);
      step();
      check("bub_b_out", 32'(a_od), 32'hB0);
      check("bub_b_sv",  32'(a_sv), 32'h7);
      drive_a(1'b0, 8'h00, 4'h0); step();
      check("bub_a_out", 32'(a_od), 32'hA0);
      step();
      check("bub_d_out",  32'(a_od), 32'hD0);
      check("bub_d_ctrl", 32'(a_oc), 32'hD);
      check("bub_stallcnt", 32'(a_sc), PERF ? 32'd2 : 32'd0);

      // Flush over stall on DEPTH=2
      b_valid = 1'b1; b_data = 8'h5A; b_ctrl = 4'h6; step();
      b_valid = 1'b0; b_data = 8'h00; b_ctrl = 4'h0;
      check("fos_load", 32'(b_sv), 32'h1);
      b_flush = 2'b01; b_stall = 2'b01;
      #1;
      check("fos_ready", 32'(b_ready), 32'h0);
      step();
      check("fos_sv",   32'(b_sv), 32'h0);
      check("fos_kill", 32'(b_kc), PERF ? 32'd1 : 32'd0);
      b_flush = 2'b00;
      b_valid = 1'b1; b_data = 8'h77; b_ctrl = 4'h7;
      step();
      check("fos_hold_sv", 32'(b_sv), 32'h0);
      b_stall = 2'b00;
      step();
      check("fos_cap_sv", 32'(b_sv), 32'h1);
      b_valid = 1'b0; b_data = 8'h00; b_ctrl = 4'h0;
      step();
      check("fos_out_d", 32'(b_od), 32'h77);
      check("fos_out_v", 32'(b_ov), 32'h1);
      check("fos_kill2", 32'(b_kc), PERF ? 32'd1 : 32'd0);
      check("fos_stall", 32'(b_sc), PERF ? 32'd2 : 32'd0);

      // Multi-kill on DEPTH=4: flush stages 0, 1, 3 while stage 2 advances
      for (int i = 0; i < 4; i++) begin
         c_valid = 1'b1; c_data = 8'h41 + 8'(i); c_ctrl = 4'(i + 1);
         step();
      end
      c_valid = 1'b0; c_data = 8'h00; c_ctrl = 4'h0;
      check("mk_full", 32'(c_sv), 32'hF);
      check("mk_out0", 32'(c_od), 32'h41);
      c_flush = 4'b1011;
      step();
      c_flush = 4'b0000;
      check("mk_sv",   32'(c_sv), 32'h4);
      check("mk_ov",   32'(c_ov), 32'h0);
      check("mk_oc",   32'(c_oc), 32'h0);
      check("mk_kill", 32'(c_kc), PERF ? 32'd3 : 32'd0);
      step();
      check("mk_adv_d", 32'(c_od), 32'h43);
      check("mk_adv_c", 32'(c_oc), 32'h3);

      // Counter saturation with CNT_W=4
      c_stall = 4'b0001;
      repeat (10) step();
      check("sat_10", 32'(c_sc), PERF ? 32'd10 : 32'd0);
      repeat (10) step();
      check("sat_20", 32'(c_sc), PERF ? 32'd15 : 32'd0);
      c_clr = 1'b1;
      step();
      c_clr = 1'b0;
      check("sat_clr",      32'(c_sc), 32'h0);
      check("sat_clr_kill", 32'(c_kc), 32'h0);
      step();
      check("sat_recount", 32'(c_sc), PERF ? 32'd1 : 32'd0);
      c_stall = 4'b0000;

      // Reset mid-stall: DEPTH=3 full and held, then reset between edges
      drive_a(1'b1, 8'hE1, 4'h1); step();
      drive_a(1'b1, 8'hE2, 4'h2); step();
      drive_a(1'b1, 8'hE3, 4'h3); step();
      drive_a(1'b0, 8'h00, 4'h0);
      a_stall = 3'b100;
      step();
      check("rmid_held_v", 32'(a_ov), 32'h1);
      check("rmid_held_d", 32'(a_od), 32'hE1);
      #2 reset = 1'b0;
      #1;
      check("rmid_sv",    32'(a_sv), 32'h0);
      check("rmid_ov",    32'(a_ov), 32'h0);
      check("rmid_od",    32'(a_od), 32'h0);
      check("rmid_oc",    32'(a_oc), 32'h0);
      check("rmid_sc",    32'(a_sc), 32'h0);
      check("rmid_kc",    32'(a_kc), 32'h0);
      check("rmid_b_kc",  32'(b_kc), 32'h0);
      check("rmid_c_sc",  32'(c_sc), 32'h0);
      #2 reset = 1'b1;
      a_stall = 3'b000;
      step();
      check("rmid_after", 32'(a_sv), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised successor to the fixed-field decode/execute pipeline register: a chain of `DEPTH` pipeline stages with a per-stage valid bit, per-stage stall and flush, and automatic bubble insertion between a held stage and a moving one. Payload and control are carried as two generic buses, so the ID/EX, EX/MEM and MEM/WB boundaries of the core all use this one block. Optional saturating counters give stall and kill statistics to the hazard-unit debug path.

## Interface
Parameters:
- `DATA_W`, default 160: payload width (operands, PC, immediate, register indices).
- `CTRL_W`, default 16: control width (regWrite, memWrite, jump, branch, ALU control, result select, ...).
- `DEPTH`, default 1: number of stages, 1..4.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `CLK`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  stage-0 input carries a real instruction.
- `in_data`  in  DATA_W  stage-0 payload.
- `in_ctrl`  in  CTRL_W  stage-0 control.
- `stall`  in  DEPTH  `stall[i]` holds stage i and every stage upstream of it.
- `flush`  in  DEPTH  `flush[i]` makes stage i a bubble on the next edge.
- `perf_clr`  in  1  synchronous clear of both counters.
- `in_ready`  out  1  stage 0 accepts input this cycle.
- `stage_valid`  out  DEPTH  valid bit of each stage register.
- `out_valid`  out  1  valid bit of stage DEPTH-1.
- `out_data`  out  DATA_W  payload of stage DEPTH-1.
- `out_ctrl`  out  CTRL_W  control of stage DEPTH-1.
- `stall_cnt`  out  CNT_W  cycles with `in_ready` low.
- `kill_cnt`  out  CNT_W  valid entries destroyed by flush.

## Operation
- Hold vector: `h[i]` is the OR of `stall[j]` for all j >= i. `in_ready` equals `~h[0]` and is combinational.
- Per stage i, at each edge, first matching rule wins:
  - `flush[i]`: becomes a bubble (valid, ctrl and data all 0). Flush overrides stall.
  - `h[i]`: holds its contents.
  - i > 0 and `h[i-1]`: becomes a bubble. This is the bubble inserted behind a held stage.
  - Otherwise: loads from stage i-1. Stage 0 loads from `in_valid`/`in_data`/`in_ctrl`.
- A bubble must never assert any control bit. Downstream logic relies on `ctrl == 0` meaning no side effects.
- Input presented while `in_ready` is low is not captured. The driver must re-present it.
- `flush` and `stall` on the same stage: flush wins, and the stage stays a bubble while the stall persists (it holds the bubble).

## Timing
- Latency: exactly `DEPTH` cycles from capture to `out_*` when nothing is stalled or flushed.
- Throughput: one entry per cycle.
- All `out_*` and `stage_valid` outputs are registered. `in_ready` is the only combinational output.
- Reset (`reset` low, asynchronous):
  - Every stage becomes a bubble.
  - `stage_valid`, `out_valid`, `out_data`, `out_ctrl`, `stall_cnt` and `kill_cnt` are all 0.
  - Effect is immediate, with no clock needed.
  - Deassertion is taken synchronously by the surrounding reset synchroniser.
  - Reset asserted mid-stall discards all held entries.
- `DEPTH` = 1 degenerates to a single register with hold and flush, behaving like the original ID/EX register plus stall.

## Configuration
- Macro `PIPE_STAGE_CHAIN_PERF_EN`.
- Defined:
  - `stall_cnt` increments by 1 on every edge where `in_ready` is low.
  - `kill_cnt` increments by the popcount of `flush & stage_valid` on every edge.
  - Both counters saturate at all-ones and never wrap.
  - `perf_clr` zeroes both counters and takes priority over increment in the same cycle.
- Not defined:
  - Counters are not built.
  - `stall_cnt` and `kill_cnt` are constant 0.
  - `perf_clr` is ignored.
  - Stage behaviour is identical in both builds.

## Test plan
- Streaming, `DEPTH`=3, no stall or flush: present data values 0x11, 0x22, 0x33 with `in_valid`=1 on consecutive cycles -> `out_data` shows 0x11, 0x22, 0x33 on cycles 3, 4, 5, each with `out_valid`=1.
- Bubble insertion, `DEPTH`=3, pipe full with A, B, C (C in stage 2): `stall[1]` high for 2 cycles -> C leaves on the first edge; stage 2 is a bubble (`ctrl`=0, `out_valid`=0) for 2 cycles; stages 0 and 1 still hold their entries; `in_ready`=0 for those 2 cycles.
- Flush over stall, `DEPTH`=2: `flush[0]` and `stall[0]` asserted together with stage 0 valid -> on the next edge `stage_valid[0]`=0 and the stage holds the bubble until the stall drops. With the perf macro defined, `kill_cnt` rises by exactly 1.
- Multi-kill, `DEPTH`=4, all stages valid: `flush`=4'b1011 for one cycle -> stages 0, 1 and 3 become bubbles and stage 2 advances normally. With the macro defined, `kill_cnt` rises by 3.
- Reset mid-operation: pull `reset` low between clock edges while stalled with valid entries -> all outputs read 0 before the next edge and both counters read 0.
- Counter saturation, `CNT_W`=4, macro defined: hold `stall[0]` for 20 cycles -> `stall_cnt` reaches 15 and stays there. Then pulse `perf_clr` while the stall is still high -> `stall_cnt` reads 0 after the edge, then counts up from 0 again.
